// File: rtl/echo_responder.sv
// Echo responder: payloads accepted on "say" are replayed in order on "heard" through a DEPTH-entry circular buffer.
// Optional feature: define ECHO_RESPONDER_STATS_EN to add the 32-bit heard_total transfer counter.
module echo_responder #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     CLK,
  input  logic                     nRST,
  input  logic                     say__ENA,
  input  logic [WIDTH-1:0]         say_v,
  output logic                     say__RDY,
  output logic                     ind_heard__ENA,
  output logic [WIDTH-1:0]         ind_heard_v,
  input  logic                     ind_heard__RDY,
`ifdef ECHO_RESPONDER_STATS_EN
  output logic [31:0]              heard_total,
`endif
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic [AW:0]      w_count_nxt;
  logic             w_wr_fire;
  logic             w_rd_fire;

  // Handshakes derive from registered occupancy only, so there is no say-to-heard bypass.
  assign say__RDY       = (r_count != FULL_CNT);
  assign ind_heard__ENA = (r_count != {(AW+1){1'b0}}) && ind_heard__RDY;
  assign ind_heard_v    = r_mem[r_rd_ptr];
  assign count          = r_count;
  assign w_wr_fire      = say__ENA && say__RDY;
  assign w_rd_fire      = ind_heard__ENA;

  // Occupancy next-state: simultaneous write and read cancel out.
  always_comb begin
    w_count_nxt = r_count;
    case ({w_wr_fire, w_rd_fire})
      2'b10:   w_count_nxt = r_count + CNT_ONE;
      2'b01:   w_count_nxt = r_count - CNT_ONE;
      default: w_count_nxt = r_count;
    endcase
  end

  // Pointer and occupancy registers; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_wr_ptr <= {AW{1'b0}};
      r_rd_ptr <= {AW{1'b0}};
      r_count  <= {(AW+1){1'b0}};
    end else begin
      if (w_wr_fire) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_rd_fire) r_rd_ptr <= r_rd_ptr + PTR_ONE;
      r_count <= w_count_nxt;
    end
  end

  // Payload storage; contents survive reset and are simply abandoned by the pointer clear.
  always_ff @(posedge CLK) begin
    if (w_wr_fire) r_mem[r_wr_ptr] <= say_v;
  end

`ifdef ECHO_RESPONDER_STATS_EN
  logic [31:0] r_heard_total;

  assign heard_total = r_heard_total;

  // Completed heard transfers, wrapping at 2^32.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_heard_total <= 32'd0;
    end else if (w_rd_fire) begin
      r_heard_total <= r_heard_total + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_echo_responder.sv
// Self-checking bench for echo_responder: directed scenarios plus random traffic against a queue model.
// Define ECHO_RESPONDER_STATS_EN for both files to exercise the heard_total counter.
module tb_echo_responder;

  localparam int WIDTH = 32;
  localparam int DEPTH = 4;

  logic             CLK = 1'b0;
  logic             nRST;
  logic             say__ENA;
  logic [WIDTH-1:0] say_v;
  logic             say__RDY;
  logic             ind_heard__ENA;
  logic [WIDTH-1:0] ind_heard_v;
  logic             ind_heard__RDY;
  logic [2:0]       count;
`ifdef ECHO_RESPONDER_STATS_EN
  logic [31:0]      heard_total;
  logic [31:0]      exp_total;
`endif

  int checks   = 0;
  int failures = 0;
  logic [WIDTH-1:0] q[$];

  echo_responder #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .CLK            (CLK),
    .nRST           (nRST),
    .say__ENA       (say__ENA),
    .say_v          (say_v),
    .say__RDY       (say__RDY),
    .ind_heard__ENA (ind_heard__ENA),
    .ind_heard_v    (ind_heard_v),
    .ind_heard__RDY (ind_heard__RDY),
`ifdef ECHO_RESPONDER_STATS_EN
    .heard_total    (heard_total),
`endif
    .count          (count)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs after the falling edge, check against the queue model, then commit.
  task automatic step(input logic ena, input logic [WIDTH-1:0] v, input logic rdy);
    logic exp_rdy;
    logic exp_ena;
    @(negedge CLK);
    say__ENA = ena;
    say_v = v;
    ind_heard__RDY = rdy;
    #1;
    exp_rdy = (q.size() != DEPTH);
    exp_ena = (q.size() != 0) && rdy;
    chk("say_rdy", {31'd0, say__RDY}, {31'd0, exp_rdy});
    chk("heard_ena", {31'd0, ind_heard__ENA}, {31'd0, exp_ena});
    chk("count", {29'd0, count}, 32'(q.size()));
    if (exp_ena) chk("heard_v", ind_heard_v, q[0]);
`ifdef ECHO_RESPONDER_STATS_EN
    chk("heard_total", heard_total, exp_total);
    if (exp_ena) exp_total = exp_total + 32'd1;
`endif
    if (exp_ena) void'(q.pop_front());
    if (ena && exp_rdy) q.push_back(v);
    @(posedge CLK);
  endtask

  initial begin
    nRST = 1'b0;
    say__ENA = 1'b0;
    say_v = '0;
    ind_heard__RDY = 1'b1;
`ifdef ECHO_RESPONDER_STATS_EN
    exp_total = 32'd0;
`endif
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_count", {29'd0, count}, 32'd0);
    chk("rst_say_rdy", {31'd0, say__RDY}, 32'd1);
    chk("rst_heard_ena", {31'd0, ind_heard__ENA}, 32'd0);
    @(negedge CLK);
    nRST = 1'b1;

    // In-order echo with one cycle of latency.
    step(1'b1, 32'h11, 1'b1);
    step(1'b1, 32'h22, 1'b1);
    step(1'b1, 32'h33, 1'b1);
    step(1'b0, 32'h0, 1'b1);
    step(1'b0, 32'h0, 1'b1);

    // Fill with consumer stalled, fifth held off, then drain with say held at full.
    for (int i = 1; i <= 4; i++) step(1'b1, 32'hA0 + 32'(i), 1'b0);
    step(1'b1, 32'hA5, 1'b0);
    step(1'b1, 32'hA5, 1'b1);
    step(1'b1, 32'hA5, 1'b1);
    for (int i = 0; i < 6; i++) step(1'b0, 32'h0, 1'b1);

    // Steady state at count=2 with simultaneous accept and delivery; pointers wrap.
    step(1'b1, 32'hB0, 1'b0);
    step(1'b1, 32'hB1, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b1, 32'hC0 + 32'(i), 1'b1);
    step(1'b0, 32'h0, 1'b0);
    chk("steady_count", {29'd0, count}, 32'd2);

    // Reset mid-stream with three entries buffered.
    step(1'b1, 32'hD0, 1'b0);
    @(negedge CLK);
    say__ENA = 1'b0;
    ind_heard__RDY = 1'b1;
    #2;
    nRST = 1'b0;
    #1;
    chk("midrst_count", {29'd0, count}, 32'd0);
    chk("midrst_say_rdy", {31'd0, say__RDY}, 32'd1);
    chk("midrst_heard_ena", {31'd0, ind_heard__ENA}, 32'd0);
    q.delete();
`ifdef ECHO_RESPONDER_STATS_EN
    exp_total = 32'd0;
`endif
    @(negedge CLK);
    nRST = 1'b1;
    step(1'b0, 32'h0, 1'b1);
    step(1'b1, 32'hE1, 1'b1);
    step(1'b0, 32'h0, 1'b1);
    step(1'b0, 32'h0, 1'b1);

    // Random traffic, including say attempts while not ready.
    for (int i = 0; i < 400; i++)
      step(($urandom_range(0, 3) != 0), WIDTH'($urandom), ($urandom_range(0, 2) != 0));
    for (int i = 0; i < 6; i++) step(1'b0, 32'h0, 1'b1);

`ifdef ECHO_RESPONDER_STATS_EN
    // Preset the transfer counter two short of wrap and push two payloads through.
    @(negedge CLK);
    dut.r_heard_total = 32'hFFFF_FFFE;
    exp_total = 32'hFFFF_FFFE;
    step(1'b1, 32'hF1, 1'b1);
    step(1'b1, 32'hF2, 1'b1);
    step(1'b0, 32'h0, 1'b1);
    step(1'b0, 32'h0, 1'b1);
    chk("wrap_total", heard_total, 32'h0000_0000);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
